// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C 16-bit register write engine:
//   - i2c_state_e : controller state encoding (also exported on the debug port)
//   - START_Q / BIT_Q / STOP_Q : number of quarter-bit periods per bus phase
//   - MAX_BYTES   : largest payload (bytes after the address byte)
//   - NUM_SLOTS   : address byte plus the maximum payload
//   - clamp_bytes : limits a requested payload count to a maximum
// ---------------------------------------------------------------------------
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        BIT   = 3'd2,
        ACK   = 3'd3,
        STOP  = 3'd4,
        DONE  = 3'd5
    } i2c_state_e;

    localparam int START_Q   = 2;
    localparam int BIT_Q     = 4;
    localparam int STOP_Q    = 3;
    localparam int MAX_BYTES = 4;
    localparam int NUM_SLOTS = MAX_BYTES + 1;

    // Requested payload counts above max_n are treated as max_n.
    function automatic logic [2:0] clamp_bytes(input logic [2:0] n, input int max_n);
        if (int'(n) > max_n) begin
            return 3'(max_n);
        end
        return n;
    endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// ---------------------------------------------------------------------------
// i2c_quarter_tick
// Divides the system clock into quarter-bit periods and tracks which quarter
// of the current bus phase is active.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   i_en       counting enable; when low the counter and quarter index clear
//   i_hold     freeze the counter for this cycle (slave clock stretching)
//   i_last_q   index of the final quarter of the current bus phase
//   o_tick     high on the last cycle of a quarter
//   o_quarter  index of the current quarter within the bus phase
// ---------------------------------------------------------------------------
module i2c_quarter_tick #(
    parameter int PHASE_DIV = 31
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic       i_hold,
    input  logic [1:0] i_last_q,
    output logic       o_tick,
    output logic [1:0] o_quarter
);

    localparam int CW = (PHASE_DIV < 1) ? 1 : $clog2(PHASE_DIV + 1);

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_quarter;
    logic          w_wrap;

    assign w_wrap    = (r_cnt == CW'(PHASE_DIV));
    assign o_tick    = i_en && !i_hold && w_wrap;
    assign o_quarter = r_quarter;

    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_cnt     <= '0;
            r_quarter <= 2'd0;
        end else if (!i_hold) begin
            if (w_wrap) begin
                r_cnt <= '0;
                // The quarter index wraps at the end of each bus phase so the
                // next phase (or the next bit) always starts at quarter 0.
                if (r_quarter == i_last_q) begin
                    r_quarter <= 2'd0;
                end else begin
                    r_quarter <= r_quarter + 2'd1;
                end
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/i2c_wr16_master.sv
// ---------------------------------------------------------------------------
// i2c_wr16_master
// Byte-level I2C write engine: one register write per transaction
// (address byte, then up to four payload bytes: POINTER hi/lo, WDATA hi/lo),
// MSB first, with ACK checking after every byte, framed by START and STOP.
// Bus outputs are open-drain style (1 = release the line).
//
// Optional build macro: I2C_CLK_STRETCH_EN
//   Defined   : while SCL is released but read back low, the quarter counter
//               holds (slave clock stretching).
//   Undefined : SCL_I is ignored, timing is fixed.
//
// Ports:
//   CLK_50       system clock
//   RESET        synchronous active-high reset
//   GO           start request, sampled only in IDLE
//   SLAVE_ADDR   8-bit write address (bit0 forced to 0 on the bus)
//   POINTER      register pointer, payload bytes 1-2
//   WDATA        write data, payload bytes 3-4
//   BYTE_NUM     payload byte count 0..4, larger values clamp to MAX_BYTES
//   SDA_I        SDA pad readback (ACK sampling)
//   SCL_I        SCL pad readback (clock stretching only)
//   SCL_O/SDA_O  line drives, 1 = release
//   BUSY         high from GO accept until END_OK
//   END_OK       one-cycle completion pulse after STOP
//   ACK_ERR      a NACK was seen in the last transaction
//   o_dbg_state  current controller state (i2c_state_e encoding)
//
// Request handshake: GO is a level request. It is accepted on any clock edge
// where the controller is IDLE and GO is high; that edge latches all request
// inputs and raises BUSY. GO is ignored while BUSY is high. Completion is the
// END_OK pulse, which coincides with BUSY falling; the controller is IDLE in
// that same cycle, so a GO still held high is accepted on the following edge.
// ---------------------------------------------------------------------------
module i2c_wr16_master #(
    parameter int PHASE_DIV = 31,
    parameter int MAX_BYTES = i2c_pkg::MAX_BYTES
) (
    input  logic        CLK_50,
    input  logic        RESET,
    input  logic        GO,
    input  logic [7:0]  SLAVE_ADDR,
    input  logic [15:0] POINTER,
    input  logic [15:0] WDATA,
    input  logic [2:0]  BYTE_NUM,
    input  logic        SDA_I,
    input  logic        SCL_I,
    output logic        SCL_O,
    output logic        SDA_O,
    output logic        BUSY,
    output logic        END_OK,
    output logic        ACK_ERR,
    output logic [2:0]  o_dbg_state
);

    import i2c_pkg::*;

    i2c_state_e  r_state;
    i2c_state_e  w_next;

    logic [7:0]  r_bytes [NUM_SLOTS];
    logic [2:0]  r_byte_idx;
    logic [2:0]  r_bit_idx;
    logic [2:0]  r_nbytes;
    logic        r_nack;
    logic        r_scl_o;
    logic        r_sda_o;
    logic        r_busy;
    logic        r_end_ok;
    logic        r_ack_err;

    logic        w_accept;
    logic        w_en;
    logic        w_hold;
    logic        w_tick;
    logic [1:0]  w_quarter;
    logic [1:0]  w_last_q;
    logic        w_phase_end;
    logic        w_scl;
    logic        w_sda;
    logic        w_data_bit;

    assign w_accept    = (r_state == IDLE) && GO;
    assign w_en        = (r_state != IDLE) && (r_state != DONE);
    assign w_phase_end = w_tick && (w_quarter == w_last_q);
    assign w_data_bit  = r_bytes[r_byte_idx][r_bit_idx];

`ifdef I2C_CLK_STRETCH_EN
    // r_scl_o is what is actually on the pad this cycle; if it is released
    // but the pad still reads low, a slave is stretching the clock.
    assign w_hold = r_scl_o && !SCL_I;
`else
    logic w_unused_scl;
    assign w_unused_scl = SCL_I;
    assign w_hold       = 1'b0;
`endif

    i2c_quarter_tick #(
        .PHASE_DIV (PHASE_DIV)
    ) u_tick (
        .clk       (CLK_50),
        .rst       (RESET),
        .i_en      (w_en),
        .i_hold    (w_hold),
        .i_last_q  (w_last_q),
        .o_tick    (w_tick),
        .o_quarter (w_quarter)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_50) begin
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and per-quarter line levels
    // ------------------------------------------------------------------
    always_comb begin
        w_next   = r_state;
        w_scl    = 1'b1;
        w_sda    = 1'b1;
        w_last_q = 2'd0;
        case (r_state)
            IDLE: begin
                if (GO) begin
                    w_next = START;
                end
            end
            START: begin
                w_last_q = 2'(START_Q - 1);
                w_scl    = (w_quarter == 2'd0);
                w_sda    = 1'b0;
                if (w_phase_end) begin
                    w_next = BIT;
                end
            end
            BIT: begin
                w_last_q = 2'(BIT_Q - 1);
                w_scl    = (w_quarter == 2'd1) || (w_quarter == 2'd2);
                w_sda    = w_data_bit;
                if (w_phase_end && (r_bit_idx == 3'd0)) begin
                    w_next = ACK;
                end
            end
            ACK: begin
                w_last_q = 2'(BIT_Q - 1);
                w_scl    = (w_quarter == 2'd1) || (w_quarter == 2'd2);
                w_sda    = 1'b1;
                if (w_phase_end) begin
                    // A NACK abandons the remaining payload.
                    if (r_nack || (r_byte_idx == r_nbytes)) begin
                        w_next = STOP;
                    end else begin
                        w_next = BIT;
                    end
                end
            end
            STOP: begin
                w_last_q = 2'(STOP_Q - 1);
                w_scl    = (w_quarter != 2'd0);
                w_sda    = (w_quarter == 2'd2);
                if (w_phase_end) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath, registered line drives and status
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_50) begin
        if (RESET) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_bytes[i] <= 8'h00;
            end
            r_byte_idx <= 3'd0;
            r_bit_idx  <= 3'd7;
            r_nbytes   <= 3'd0;
            r_nack     <= 1'b0;
            r_scl_o    <= 1'b1;
            r_sda_o    <= 1'b1;
            r_busy     <= 1'b0;
            r_end_ok   <= 1'b0;
            r_ack_err  <= 1'b0;
        end else begin
            // Line drives are registered so the pads never see decode glitches;
            // the whole bus waveform is simply one cycle behind the state.
            r_scl_o  <= w_scl;
            r_sda_o  <= w_sda;
            r_end_ok <= (r_state == DONE);

            if (r_state == DONE) begin
                r_busy <= 1'b0;
            end

            if (w_accept) begin
                r_bytes[0] <= SLAVE_ADDR & 8'hFE;
                r_bytes[1] <= POINTER[15:8];
                r_bytes[2] <= POINTER[7:0];
                r_bytes[3] <= WDATA[15:8];
                r_bytes[4] <= WDATA[7:0];
                r_nbytes   <= clamp_bytes(BYTE_NUM, MAX_BYTES);
                r_byte_idx <= 3'd0;
                r_bit_idx  <= 3'd7;
                r_nack     <= 1'b0;
                r_busy     <= 1'b1;
                r_ack_err  <= 1'b0;
            end

            // Bit index counts 7..0 and wraps back to 7 for the next byte.
            if ((r_state == BIT) && w_phase_end) begin
                r_bit_idx <= r_bit_idx - 3'd1;
            end

            if ((r_state == ACK) && w_tick) begin
                if (w_quarter == 2'd2) begin
                    r_nack <= SDA_I;
                    if (SDA_I) begin
                        r_ack_err <= 1'b1;
                    end
                end
                if ((w_quarter == 2'd3) && !r_nack && (r_byte_idx != r_nbytes)) begin
                    r_byte_idx <= r_byte_idx + 3'd1;
                end
            end
        end
    end

    assign SCL_O       = r_scl_o;
    assign SDA_O       = r_sda_o;
    assign BUSY        = r_busy;
    assign END_OK      = r_end_ok;
    assign ACK_ERR     = r_ack_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_i2c_wr16_master.sv
`timescale 1ns/1ps
module tb_i2c_wr16_master;
    import i2c_pkg::*;

    localparam int PD = 3;
    localparam int QC = PD + 1;
    localparam int TIMEOUT = 5000;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    logic        go = 1'b0;
    logic [7:0]  slave_addr = 8'h00;
    logic [15:0] pointer = 16'h0000;
    logic [15:0] wdata = 16'h0000;
    logic [2:0]  byte_num = 3'd0;
    logic        sda_i;
    logic        scl_i;
    logic        scl_o;
    logic        sda_o;
    logic        busy;
    logic        end_ok;
    logic        ack_err;
    logic [2:0]  dbg_state;

    logic slave_sda = 1'b1;
    logic stretch_on = 1'b0;

    assign sda_i = sda_o & slave_sda;
    assign scl_i = scl_o & ~stretch_on;

    i2c_wr16_master #(
        .PHASE_DIV (PD)
    ) dut (
        .CLK_50      (clk),
        .RESET       (rst),
        .GO          (go),
        .SLAVE_ADDR  (slave_addr),
        .POINTER     (pointer),
        .WDATA       (wdata),
        .BYTE_NUM    (byte_num),
        .SDA_I       (sda_i),
        .SCL_I       (scl_i),
        .SCL_O       (scl_o),
        .SDA_O       (sda_o),
        .BUSY        (busy),
        .END_OK      (end_ok),
        .ACK_ERR     (ack_err),
        .o_dbg_state (dbg_state)
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int got_rd  = 0;
    int end_cnt = 0;
    int nack_at = 99;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Slave bus model: decodes START/STOP/bytes, ACKs unless told to NACK
    // ------------------------------------------------------------------
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    int         bitcnt   = 0;
    int         byte_cnt = 0;
    logic [7:0] shreg    = 8'h00;

    always @(negedge clk) begin
        logic l_sda;
        l_sda = sda_o & slave_sda;
        if (rst) begin
            prev_scl  = 1'b1;
            prev_sda  = 1'b1;
            bitcnt    = 0;
            slave_sda = 1'b1;
        end else begin
            if (scl_o && prev_scl && prev_sda && !l_sda) begin
                bitcnt    = 0;
                byte_cnt  = 0;
                slave_sda = 1'b1;
            end else if (scl_o && prev_scl && !prev_sda && l_sda) begin
                bitcnt    = 0;
                slave_sda = 1'b1;
            end else if (scl_o && !prev_scl) begin
                bitcnt++;
                if (bitcnt <= 8) begin
                    shreg = {shreg[6:0], l_sda};
                    if (bitcnt == 8) got_q.push_back(shreg);
                end
            end else if (!scl_o && prev_scl) begin
                if (bitcnt == 8) begin
                    slave_sda = (byte_cnt == nack_at) ? 1'b1 : 1'b0;
                end else if (bitcnt == 9) begin
                    slave_sda = 1'b1;
                    bitcnt    = 0;
                    byte_cnt++;
                end
            end
            prev_scl = scl_o;
            prev_sda = l_sda;
        end
    end

    always @(negedge clk) begin
        if (end_ok === 1'b1) end_cnt++;
    end

`ifdef I2C_CLK_STRETCH_EN
    // Holds SCL low across exactly STRETCH released cycles, starting from a
    // low phase of the first data bit so the whole rising quarter is held.
    localparam int STRETCH = 20;
    logic stretch_req  = 1'b0;
    logic stretch_done = 1'b0;
    int   st_cnt       = 0;
    always @(negedge clk) begin
        if (stretch_req && !stretch_done && !stretch_on && !scl_o && dbg_state == 3'(BIT)) begin
            stretch_on   = 1'b1;
            stretch_done = 1'b1;
            st_cnt       = 0;
        end else if (stretch_on) begin
            if (st_cnt == STRETCH) stretch_on = 1'b0;
            else if (scl_o) st_cnt++;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic [7:0]  addr;
        logic [15:0] ptr;
        logic [15:0] wdata;
        logic [2:0]  bnum;
        int          nack;
        bit          spam;
        int          exp_nbytes;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic push_expected(input vec_t v);
        logic [7:0] b [5];
        int n;
        int nsend;
        b[0] = v.addr & 8'hFE;
        b[1] = v.ptr[15:8];
        b[2] = v.ptr[7:0];
        b[3] = v.wdata[15:8];
        b[4] = v.wdata[7:0];
        n = (v.bnum > 3'd4) ? 4 : int'(v.bnum);
        nsend = n + 1;
        if (v.nack < nsend) nsend = v.nack + 1;
        for (int i = 0; i < nsend; i++) exp_q.push_back(b[i]);
    endtask

    task automatic drive_go(input vec_t v, input bit hold_go, input string tag);
        @(negedge clk);
        slave_addr = v.addr;
        pointer    = v.ptr;
        wdata      = v.wdata;
        byte_num   = v.bnum;
        nack_at    = v.nack;
        go         = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_go) go = 1'b0;
        check({tag, "_busy_at_accept"}, busy, 1);
        check({tag, "_ackerr_cleared"}, ack_err, 0);
    endtask

    task automatic wait_end(input bit spam, output int c);
        c = 0;
        while (end_ok !== 1'b1 && c < TIMEOUT) begin
            @(posedge clk);
            #1;
            c++;
            if (spam && end_ok !== 1'b1) go = 1'($urandom_range(0, 1));
        end
        if (spam) go = 1'b0;
    endtask

    task automatic check_bytes(input string tag, input int nexp);
        logic [7:0] e;
        check({tag, "_nbytes"}, got_q.size() - got_rd, nexp);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (got_rd < got_q.size()) begin
                check({tag, "_byte"}, got_q[got_rd], e);
                got_rd++;
            end
        end
        got_rd = got_q.size();
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int c;
        int ends0;
        ends0 = end_cnt;
        push_expected(v);
        drive_go(v, 1'b0, tag);
        wait_end(v.spam, c);
        check({tag, "_latency"}, c, v.exp_lat);
        check({tag, "_ack_err"}, ack_err, v.exp_err);
        check({tag, "_busy_at_end"}, busy, 0);
        repeat (8) @(posedge clk);
        #1;
        check({tag, "_end_pulses"}, end_cnt - ends0, 1);
        check({tag, "_idle_scl"}, scl_o, 1);
        check({tag, "_idle_sda"}, sda_o, 1);
        check_bytes(tag, v.exp_nbytes);
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        vec_t vt [8];
        vec_t v;
        int   c;
        int   ends0;

        // Latency constants: (5 + 36*bytes_sent) * (PD+1) + 1
        vt[0] = '{8'h1C, 16'h0002, 16'h0001, 3'd4, 99, 1'b0, 5, 1'b0, 741};
        vt[1] = '{8'h1C, 16'h0002, 16'h0001, 3'd4,  2, 1'b0, 3, 1'b1, 453};
        vt[2] = '{8'hA5, 16'h1234, 16'h5678, 3'd2, 99, 1'b0, 3, 1'b0, 453};
        vt[3] = '{8'h3B, 16'hBEEF, 16'hCAFE, 3'd7, 99, 1'b0, 5, 1'b0, 741};
        vt[4] = '{8'h50, 16'h0F0F, 16'hF0F0, 3'd0, 99, 1'b0, 1, 1'b0, 165};
        vt[5] = '{8'h1C, 16'h0002, 16'h0001, 3'd4,  0, 1'b0, 1, 1'b1, 165};
        vt[6] = '{8'h68, 16'hAAAA, 16'h5555, 3'd3, 99, 1'b1, 4, 1'b0, 597};
        vt[7] = '{8'h00, 16'h0000, 16'h0000, 3'd4,  4, 1'b0, 5, 1'b1, 741};
        vt[7].addr  = 8'($urandom_range(0, 255));
        vt[7].ptr   = 16'($urandom_range(0, 65535));
        vt[7].wdata = 16'($urandom_range(0, 65535));

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_scl", scl_o, 1);
        check("rst_sda", sda_o, 1);
        check("rst_busy", busy, 0);
        check("rst_end_ok", end_ok, 0);
        check("rst_ack_err", ack_err, 0);
        check("rst_state", dbg_state, int'(IDLE));
        rst = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 8; i++) begin
            run_vec(vt[i], $sformatf("vec%0d", i));
        end

        // GO held high through END_OK restarts on the next cycle
        v = vt[0];
        ends0 = end_cnt;
        push_expected(v);
        drive_go(v, 1'b1, "b2b_first");
        wait_end(1'b0, c);
        check("b2b_first_latency", c, 741);
        check_bytes("b2b_first", 5);
        push_expected(v);
        @(posedge clk);
        #1;
        go = 1'b0;
        check("b2b_restart_busy", busy, 1);
        check("b2b_restart_state", dbg_state, int'(START));
        wait_end(1'b0, c);
        check("b2b_second_latency", c, 741);
        repeat (4) @(posedge clk);
        #1;
        check("b2b_end_pulses", end_cnt - ends0, 2);
        check_bytes("b2b_second", 5);

        // Reset in the 3rd bit of the second byte
        v = vt[0];
        v.nack = 99;
        exp_q.push_back(v.addr & 8'hFE);
        ends0 = end_cnt;
        drive_go(v, 1'b0, "mid_rst");
        repeat (47 * QC) @(posedge clk);
        #1;
        check("mid_rst_in_bit", dbg_state, int'(BIT));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_scl", scl_o, 1);
        check("mid_rst_sda", sda_o, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_state", dbg_state, int'(IDLE));
        repeat (30) @(posedge clk);
        #1;
        check("mid_rst_no_end", end_cnt - ends0, 0);
        check_bytes("mid_rst", 1);
        run_vec(vt[0], "after_rst");

`ifdef I2C_CLK_STRETCH_EN
        v = vt[0];
        v.exp_lat = 741 + STRETCH;
        stretch_req = 1'b1;
        run_vec(v, "stretch");
`endif

        check("exp_q_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
